// File: rtl/vga_sprite_engine.sv
// vga_sprite_engine: parametrised VGA timing generator with one scaled,
// animated, direction-transformed sprite overlaid on a background colour.
// Ports: clk/rst (async active-high); bg_rgb background; sprite_x/y/dir
// game-side position and facing; spr_addr_col/row + spr_frame to the sprite
// ROM, spr_rgb texel back (one pixel-enable later); vga_r/g/b colour;
// hsync/vsync active-low; frame_start one-clk pulse at pixel (0,0).
// Optional build macro VGA_BORDER_EN draws a white 1-pixel screen border.
module vga_sprite_engine #(
  parameter int          CLK_DIV     = 4,
  parameter int          H_ACTIVE    = 640,
  parameter int          H_FP        = 16,
  parameter int          H_SYNC      = 96,
  parameter int          H_BP        = 48,
  parameter int          V_ACTIVE    = 480,
  parameter int          V_FP        = 10,
  parameter int          V_SYNC      = 2,
  parameter int          V_BP        = 33,
  parameter int          SPR_SIZE    = 16,
  parameter int          SCALE_LOG2  = 2,
  parameter int          ANIM_FRAMES = 20,
  parameter logic [11:0] TRANSPARENT = 12'h000,
  localparam int         AW          = $clog2(SPR_SIZE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [11:0]   bg_rgb,
  input  logic [9:0]    sprite_x,
  input  logic [9:0]    sprite_y,
  input  logic [1:0]    sprite_dir,
  output logic [AW-1:0] spr_addr_col,
  output logic [AW-1:0] spr_addr_row,
  output logic [1:0]    spr_frame,
  input  logic [11:0]   spr_rgb,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);
  localparam int FW = $clog2(ANIM_FRAMES + 1);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_BLANK   = VW'(V_ACTIVE);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [FW-1:0] ANIM_LAST = FW'(ANIM_FRAMES - 1);
  localparam logic [10:0]   BOX       = 11'(SPR_SIZE << SCALE_LOG2);
  localparam logic [10:0]   HA        = 11'(H_ACTIVE);
  localparam logic [10:0]   VA        = 11'(V_ACTIVE);
  localparam logic [10:0]   HS_BEG    = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0]   HS_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG    = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0]   VS_END    = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [FW-1:0] fc_q, fc_d;
  logic [1:0]    frm_q, frm_d;
  logic          fs_q;
  logic [9:0]    x_q, y_q;
  logic [1:0]    dir_q;
  logic [AW-1:0] col_q, row_q, col_d, row_d;
  logic          box_q, act_q, hs_q, vs_q;
  logic          hso_q, vso_q;
  logic [11:0]   rgb_q, rgb_d, spr_pix, pix;
  logic          pe, sof, latch;
  logic [10:0]   h11, v11, x11, y11, dx, dy;
  logic [AW-1:0] u, w;
  logic          box_d, act_d, hs_d, vs_d;

  assign pe    = (div_q == DIV_LAST);
  assign sof   = pe && (h_q == '0) && (v_q == '0);
  // Sample game inputs at the top of vertical blank so a frame never tears.
  assign latch = pe && (h_q == '0) && (v_q == V_BLANK);

  always_comb begin
    div_d = pe ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pe) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_comb begin
    fc_d  = fc_q;
    frm_d = frm_q;
    if (sof) begin
      if (fc_q == ANIM_LAST) begin
        fc_d  = '0;
        frm_d = frm_q + 2'd1;
      end else begin
        fc_d  = fc_q + 1'b1;
      end
    end
  end

  // Stage 0: box test and texel address. 11-bit maths so a box that runs
  // past the right/bottom edge clips instead of wrapping to x/y = 0.
  always_comb begin
    h11   = 11'(h_q);
    v11   = 11'(v_q);
    x11   = {1'b0, x_q};
    y11   = {1'b0, y_q};
    dx    = h11 - x11;
    dy    = v11 - y11;
    box_d = (h11 >= x11) && (h11 < x11 + BOX) &&
            (v11 >= y11) && (v11 < y11 + BOX);
    act_d = (h11 < HA) && (v11 < VA);
    hs_d  = !((h11 >= HS_BEG) && (h11 < HS_END));
    vs_d  = !((v11 >= VS_BEG) && (v11 < VS_END));
    u     = AW'(dx >> SCALE_LOG2);
    w     = AW'(dy >> SCALE_LOG2);
    col_d = u;
    row_d = w;
    // ~u is M-u for a power-of-two sprite edge.
    unique case (dir_q)
      2'd0: begin col_d = u;  row_d = w;  end
      2'd1: begin col_d = ~u; row_d = w;  end
      2'd2: begin col_d = w;  row_d = ~u; end
      2'd3: begin col_d = w;  row_d = u;  end
    endcase
  end

  assign spr_pix = (box_q && (spr_rgb != TRANSPARENT)) ? spr_rgb : bg_rgb;

`ifdef VGA_BORDER_EN
  logic brd_q, brd_d;
  assign brd_d = (h11 == 11'd0) || (h11 == HA - 11'd1) ||
                 (v11 == 11'd0) || (v11 == VA - 11'd1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     brd_q <= 1'b0;
    else if (pe) brd_q <= brd_d;
  end
  assign pix = brd_q ? 12'hFFF : spr_pix;
`else
  assign pix = spr_pix;
`endif

  assign rgb_d = act_q ? pix : 12'h000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      fc_q  <= '0;
      frm_q <= '0;
      fs_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= '0;
      col_q <= '0;
      row_q <= '0;
      box_q <= 1'b0;
      act_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      hso_q <= 1'b1;
      vso_q <= 1'b1;
      rgb_q <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      fc_q  <= fc_d;
      frm_q <= frm_d;
      fs_q  <= sof;
      if (latch) begin
        x_q   <= sprite_x;
        y_q   <= sprite_y;
        dir_q <= sprite_dir;
      end
      if (pe) begin
        col_q <= col_d;
        row_q <= row_d;
        box_q <= box_d;
        act_q <= act_d;
        hs_q  <= hs_d;
        vs_q  <= vs_d;
        hso_q <= hs_q;
        vso_q <= vs_q;
        rgb_q <= rgb_d;
      end
    end
  end

  assign spr_addr_col = col_q;
  assign spr_addr_row = row_q;
  assign spr_frame    = frm_q;
  assign vga_r        = rgb_q[11:8];
  assign vga_g        = rgb_q[7:4];
  assign vga_b        = rgb_q[3:0];
  assign hsync        = hso_q;
  assign vsync        = vso_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// tb_vga_sprite_engine: directed bench on a shrunken 32x20 raster with
// a 4x4 sprite scaled x2; whole frames captured and probed from a table.
module tb_vga_sprite_engine;

  localparam int CD = 2;
  localparam int HA = 24, HF = 2, HS = 4, HB = 2;
  localparam int VA = 16, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int AF = 3;
  localparam int FRAME_CLK = HT * VT * CD;

`ifdef VGA_BORDER_EN
  localparam logic [11:0] E00 = 12'hFFF;
`else
  localparam logic [11:0] E00 = 12'h00F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bg;
  logic [9:0]  sx, sy;
  logic [1:0]  sdir;
  logic [1:0]  col, row, frm;
  logic [11:0] spr_rgb;
  logic [3:0]  r, g, b;
  logic        hs, vs, fs;
  int          mode;

  vga_sprite_engine #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SPR_SIZE(4), .SCALE_LOG2(1), .ANIM_FRAMES(AF),
    .TRANSPARENT(12'h000)
  ) dut (
    .clk(clk), .rst(rst), .bg_rgb(bg),
    .sprite_x(sx), .sprite_y(sy), .sprite_dir(sdir),
    .spr_addr_col(col), .spr_addr_row(row), .spr_frame(frm),
    .spr_rgb(spr_rgb),
    .vga_r(r), .vga_g(g), .vga_b(b),
    .hsync(hs), .vsync(vs), .frame_start(fs)
  );

  always #5 clk = ~clk;

  // Sprite ROM: 0 = solid F80, 1 = {1,row,col}, 2 = col 0 transparent.
  always_comb begin
    spr_rgb = 12'h000;
    case (mode)
      0:       spr_rgb = 12'hF80;
      1:       spr_rgb = {4'h1, 2'b00, row, 2'b00, col};
      default: spr_rgb = (col == 2'd0) ? 12'h000 : 12'hF80;
    endcase
  end

  typedef struct {
    int          x;
    int          y;
    int          dir;
    int          mode;
    logic [11:0] bg;
  } cfg_t;

  typedef struct {
    int          cfg;
    int          h;
    int          v;
    logic [11:0] exp;
  } vec_t;

  cfg_t cfgs [7];
  vec_t vq [$];

  logic [11:0] cap_rgb [VT][HT];
  logic        cap_hs  [VT][HT];
  logic        cap_vs  [VT][HT];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input int c, input int h, input int v,
                     input logic [11:0] e);
    vec_t t;
    t.cfg = c;
    t.h   = h;
    t.v   = v;
    t.exp = e;
    vq.push_back(t);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (fs) begin
        ok = 1'b1;
        return;
      end
    end
    chk("frame_start_timeout", 32'd0, 32'd1);
  endtask

  // Pixel k of the frame is on the pins CD*(k+1) clks after frame_start.
  task automatic capture(input int chg_k, input int new_x);
    bit ok;
    wait_fs(ok);
    if (!ok) return;
    for (int k = 0; k < HT * VT; k++) begin
      repeat (CD) @(negedge clk);
      cap_rgb[k / HT][k % HT] = {r, g, b};
      cap_hs[k / HT][k % HT]  = hs;
      cap_vs[k / HT][k % HT]  = vs;
      if (k == chg_k) sx = 10'(new_x);
    end
    chk("fs_at_frame_end", 32'(fs), 32'd1);
  endtask

  // Animation step and frame period checked on every frame_start.
  int fs_cnt = 0;
  int cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      fs_cnt = 0;
      cyc    = 0;
    end else begin
      cyc++;
      if (fs) begin
        fs_cnt++;
        chk($sformatf("anim_fs%0d", fs_cnt), 32'(frm),
            32'((fs_cnt / AF) % 4));
        if (fs_cnt > 1) chk("frame_period", 32'(cyc), 32'(FRAME_CLK));
        cyc = 0;
      end
    end
  end

  initial begin
    int cur;
    int cnt;
    int first;
    bit ok;

    cfgs[0] = '{4, 2, 0, 0, 12'h00F};
    cfgs[1] = '{4, 2, 1, 1, 12'h00F};
    cfgs[2] = '{4, 2, 2, 1, 12'h00F};
    cfgs[3] = '{4, 2, 3, 1, 12'h00F};
    cfgs[4] = '{20, 1, 0, 1, 12'h00F};
    cfgs[5] = '{1020, 0, 0, 0, 12'h00F};
    cfgs[6] = '{4, 2, 0, 2, 12'h0F0};

    add(0, 4, 2, 12'hF80);  add(0, 11, 9, 12'hF80);
    add(0, 3, 2, 12'h00F);  add(0, 12, 5, 12'h00F);
    add(0, 4, 10, 12'h00F); add(0, 4, 1, 12'h00F);
    add(0, 25, 3, 12'h000); add(0, 5, 16, 12'h000);
    add(0, 0, 0, E00);
    add(1, 4, 2, 12'h103);  add(1, 10, 2, 12'h100);
    add(1, 11, 9, 12'h130); add(1, 6, 4, 12'h112);
    add(2, 4, 2, 12'h130);  add(2, 6, 8, 12'h123);
    add(2, 11, 3, 12'h100);
    add(3, 6, 8, 12'h113);  add(3, 11, 3, 12'h130);
    add(4, 20, 1, 12'h100); add(4, 22, 2, 12'h101);
    add(4, 21, 8, 12'h130); add(4, 24, 1, 12'h000);
    add(4, 19, 1, 12'h00F);
    add(5, 1, 1, 12'h00F);  add(5, 3, 2, 12'h00F);
    add(5, 2, 5, 12'h00F);
    add(6, 4, 2, 12'h0F0);  add(6, 6, 2, 12'hF80);
    add(6, 5, 3, 12'h0F0);

    rst  = 1'b1;
    bg   = 12'h00F;
    sx   = '0;
    sy   = '0;
    sdir = '0;
    mode = 0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (201) @(negedge clk);

    // Reset mid-line: everything idles immediately, asynchronously.
    rst = 1'b1;
    #1;
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_hsync", 32'(hs), 32'd1);
    chk("rst_vsync", 32'(vs), 32'd1);
    chk("rst_fs", 32'(fs), 32'd0);
    chk("rst_frame", 32'(frm), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10 * CD; i++) begin
      @(negedge clk);
      cnt++;
      if (fs) break;
    end
    chk("first_fs_delay", 32'(cnt), 32'(CD));

    cur = -1;
    foreach (vq[i]) begin
      if (vq[i].cfg != cur) begin
        cur  = vq[i].cfg;
        sx   = 10'(cfgs[cur].x);
        sy   = 10'(cfgs[cur].y);
        sdir = 2'(cfgs[cur].dir);
        mode = cfgs[cur].mode;
        bg   = cfgs[cur].bg;
        capture(-1, 0);
        if (cur == 0) begin
          cnt = 0;
          first = -1;
          for (int h = 0; h < HT; h++)
            if (!cap_hs[3][h]) begin
              cnt++;
              if (first < 0) first = h;
            end
          chk("hsync_width", 32'(cnt), 32'(HS));
          chk("hsync_start", 32'(first), 32'(HA + HF));
          cnt = 0;
          first = -1;
          for (int v = 0; v < VT; v++)
            if (!cap_vs[v][0]) begin
              cnt++;
              if (first < 0) first = v;
            end
          chk("vsync_lines", 32'(cnt), 32'(VS));
          chk("vsync_start", 32'(first), 32'(VA + VF));
        end
      end
      chk($sformatf("vec%0d_cfg%0d_(%0d,%0d)", i, vq[i].cfg,
                    vq[i].h, vq[i].v),
          32'(cap_rgb[vq[i].v][vq[i].h]), 32'(vq[i].exp));
    end

    // Move the sprite mid-frame: current frame keeps the old x.
    capture(8 * HT, 12);
    chk("midchg_old_row9", 32'(cap_rgb[9][6]), 32'h0F80);
    chk("midchg_old_row2", 32'(cap_rgb[2][6]), 32'h0F80);
    capture(-1, 0);
    chk("midchg_new_bg", 32'(cap_rgb[2][6]), 32'h00F0);
    chk("midchg_new_spr", 32'(cap_rgb[2][14]), 32'h0F80);

    // Run on until the animation has wrapped 3 -> 0.
    for (int i = 0; i < 20 && fs_cnt < 13; i++) begin
      wait_fs(ok);
      if (!ok) break;
    end
    chk("anim_wrapped", 32'(fs_cnt >= 13), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
Name: vga_sprite_engine

Overview:
Parametrised successor to the single-sprite VGA renderer. Generates VGA timing from the 100 MHz board clock via an internal pixel-enable divider, with all porch, sync and active widths parametrised. Overlays one animated, scaled, direction-transformed sprite on a background colour. Fetches sprite texels from an external sprite ROM through a fixed-latency address/data interface. Sits between game logic (position, direction, background) and the Basys 3 VGA pins.

Parameters:
CLK_DIV, 4, clk cycles per pixel; pixel enable pulses once every CLK_DIV cycles (must be ≥2)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
SPR_SIZE, 16, sprite edge in texels (power of 2)
SCALE_LOG2, 2, sprite scale = 2^SCALE_LOG2 screen pixels per texel
ANIM_FRAMES, 20, video frames per animation step
TRANSPARENT, 12'h000, texel colour treated as transparent

Ports:
clk  in  1  board clock
rst  in  1  asynchronous, active-high reset
bg_rgb  in  12  background colour {R,G,B}
sprite_x  in  10  sprite top-left x, screen pixels
sprite_y  in  10  sprite top-left y, screen pixels
sprite_dir  in  2  0=right 1=left 2=up 3=down
spr_addr_col  out  log2(SPR_SIZE)  texel column to ROM
spr_addr_row  out  log2(SPR_SIZE)  texel row to ROM
spr_frame  out  2  animation frame select to ROM
spr_rgb  in  12  texel from ROM, valid one pixel-enable after address
vga_r / vga_g / vga_b  out  4 each  colour outputs
hsync  out  1  active-low
vsync  out  1  active-low
frame_start  out  1  one-clk pulse when counters enter (0,0)

Behaviour:
- Reset (async, active-high): divider, h_cnt, v_cnt, frame counter, spr_frame = 0; colour outputs = 0; hsync = vsync = 1; frame_start = 0; latched position/direction = 0. Deassertion restarts at pixel (0,0).
- Pixel enable (pe): single clk-wide pulse every CLK_DIV clks; all pipeline and counter logic advances only on pe. No derived clocks.
- Counters: h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params), wraps to 0 and increments v_cnt; v_cnt wraps at V_TOTAL-1.
- Sync: hsync low iff H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync same form. Sync outputs delayed by the pipeline depth (2 pe) so they stay aligned with colour.
- Position latch: sprite_x/y/dir sampled on the pe where h_cnt=0, v_cnt=V_ACTIVE (start of vertical blank); held constant for the next visible frame (no tearing).
- Stage 0 (pe n): in_box = x_lat ≤ h_cnt < x_lat + SPR_SIZE<<SCALE_LOG2, same for y; compare in 11 bits so boxes crossing the right/bottom edge clip instead of wrapping. u = (h_cnt−x_lat)>>SCALE_LOG2, v = (v_cnt−y_lat)>>SCALE_LOG2. Address transform, M = SPR_SIZE−1: right (col=u,row=v); left (col=M−u,row=v); up (col=v,row=M−u); down (col=v,row=u). Address registered.
- Stage 1 (pe n+1): spr_rgb valid. Stage 2 output register: if active (delayed h<H_ACTIVE and v<V_ACTIVE): in_box_d && spr_rgb≠TRANSPARENT ? spr_rgb : bg_rgb; else 0.
- Animation: frame counter increments at each frame_start; on reaching ANIM_FRAMES−1 it clears and spr_frame increments, wrapping 3→0.
- spr_addr_* are don't-care outside in_box but must remain in range.

Optional Feature:
VGA_BORDER_EN: when defined, active pixels with x=0, x=H_ACTIVE−1, y=0 or y=V_ACTIVE−1 output 12'hFFF, overriding sprite and background; same 2-pe latency. When undefined: no border logic, those pixels follow normal sprite/background rules.

Test Plan:
- Reset mid-line (h_cnt≈300) → outputs 0, hsync=vsync=1 during reset; first frame_start exactly 1 clk after the first pe following release; 800×525×4 clks between subsequent frame_start pulses.
- Default timing → hsync low for exactly 96×4 clks starting h=656 (+2 pe delay); vsync low for exactly 2 lines starting v=490.
- sprite_x=100, sprite_y=50, dir=0, ROM returns 12'hF80 for all texels, bg=12'h00F → colour F80 for x 100..163, y 50..113 only; 00F elsewhere in active area; 0 in blanking.
- dir=1, ROM = col index in low nibble → screen x=100..103 shows col 15; x=160..163 shows col 0; dir=2 → addressed row = 15−u, col = v.
- sprite_x=620 → sprite visible on x 620..639 only; line 0 unaffected (no wraparound); change sprite_x mid-frame → no effect until the next frame.
- Run 60 frames → spr_frame sequence 0,1,2 stepping every 20 frame_start pulses; TRANSPARENT texels show bg_rgb; with VGA_BORDER_EN, pixel (0,0) = FFF.
